// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm melody sequencer: state encoding,
// note half-period constants and the melody ROM contents.
package alarm_pkg;

  localparam int ROM_W = 20;
  localparam int HP_W  = 17;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_PLAY   = 2'd1;
  localparam state_t ST_GAP    = 2'd2;
  localparam state_t ST_SNOOZE = 2'd3;

  localparam logic [HP_W-1:0] HP_A4   = 17'd113636;
  localparam logic [HP_W-1:0] HP_C5   = 17'd95556;
  localparam logic [HP_W-1:0] HP_E5   = 17'd75842;
  localparam logic [HP_W-1:0] HP_G5   = 17'd63776;
  localparam logic [HP_W-1:0] HP_REST = 17'd0;

  // Each entry is {half_period, beats}; a zero half-period is a rest.
  localparam logic [ROM_W-1:0] MELODY [8] = '{
    {HP_C5,   3'd2},
    {HP_E5,   3'd2},
    {HP_G5,   3'd2},
    {HP_REST, 3'd1},
    {HP_G5,   3'd1},
    {HP_E5,   3'd1},
    {HP_C5,   3'd2},
    {HP_REST, 3'd1}
  };

endpackage

// File: rtl/melody_rom.sv
// Combinational melody lookup; kept separate so the tune can be swapped
// without touching the sequencer.
module melody_rom
  import alarm_pkg::*;
(
  input  logic [2:0]       idx_i,
  output logic [ROM_W-1:0] entry_o
);

  assign entry_o = MELODY[idx_i];

endmodule

// File: rtl/alarm_melody_sequencer.sv
// Steps through the melody ROM on an alarm, producing a registered tone
// enable and half-period word for the square-wave tone stage.
module alarm_melody_sequencer
  import alarm_pkg::*;
#(
  parameter int unsigned BEAT_CYCLES  = 25_000_000,
  parameter int unsigned GAP_CYCLES   = 2_500_000,
  parameter int unsigned SNOOZE_BEATS = 1200,
  parameter int unsigned REPEATS      = 60
) (
  input  logic            CLK100MHZ,
  input  logic            reset,
  input  logic            alarm_trigger,
  input  logic            snooze,
  input  logic            stop,
  output logic            tone_en,
  output logic [HP_W-1:0] note_half_period,
  output logic [2:0]      note_idx,
  output logic            active,
  output logic            snoozing,
  output logic            done
);

  localparam int CNT_W  = $clog2(7 * BEAT_CYCLES);
  localparam int BEAT_W = (SNOOZE_BEATS > 1) ? $clog2(SNOOZE_BEATS) : 1;
  localparam int LOOP_W = (REPEATS > 2) ? $clog2(REPEATS) : 1;

  localparam logic [CNT_W-1:0]  GAP_LAST    = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0]  BEAT_LAST   = CNT_W'(BEAT_CYCLES - 1);
  localparam logic [BEAT_W-1:0] SNOOZE_LAST = BEAT_W'(SNOOZE_BEATS - 1);
  localparam logic [LOOP_W-1:0] LOOP_LAST   = LOOP_W'((REPEATS > 0) ? REPEATS - 1 : 0);

  state_t            state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  logic [LOOP_W-1:0] loop_q, loop_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [CNT_W-1:0]  play_last_q, play_last_d;
  logic              tone_en_q, tone_en_d;
  logic [HP_W-1:0]   hp_q, hp_d;
  logic              done_q, done_d;
  logic [ROM_W-1:0]  next_entry;
  logic [31:0]       play_len;

  // Outputs are registered, so the ROM is read at the note about to be shown.
  melody_rom u_rom (
    .idx_i   (idx_d),
    .entry_o (next_entry)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    loop_d  = loop_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (alarm_trigger) begin
          state_d = ST_PLAY;
          idx_d   = 3'd0;
          loop_d  = '0;
        end
      end
      ST_PLAY: begin
        if (cnt_q == play_last_q) state_d = ST_GAP;
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          if (idx_q != 3'd7) begin
            state_d = ST_PLAY;
            idx_d   = idx_q + 3'd1;
          end else if (REPEATS == 0 || loop_q < LOOP_LAST) begin
            state_d = ST_PLAY;
            idx_d   = 3'd0;
            if (REPEATS != 0) loop_d = loop_q + 1'b1;
          end else begin
            state_d = ST_IDLE;
            idx_d   = 3'd0;
            loop_d  = '0;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        if (cnt_q == BEAT_LAST && beat_q == SNOOZE_LAST) begin
          state_d = ST_PLAY;
          idx_d   = 3'd0;
          loop_d  = '0;
        end
      end
    endcase

    if ((state_q == ST_PLAY || state_q == ST_GAP) && snooze) begin
      state_d = ST_SNOOZE;
      idx_d   = 3'd0;
      loop_d  = '0;
      done_d  = 1'b0;
    end

    if (stop) begin
      state_d = ST_IDLE;
      idx_d   = 3'd0;
      loop_d  = '0;
      done_d  = 1'b0;
    end

    // Counters restart on every state entry; snooze rolls cycles into beats.
    if (state_d != state_q || state_q == ST_IDLE) begin
      cnt_d  = '0;
      beat_d = '0;
    end else if (state_q == ST_SNOOZE && cnt_q == BEAT_LAST) begin
      cnt_d  = '0;
      beat_d = beat_q + 1'b1;
    end else begin
      cnt_d  = cnt_q + 1'b1;
      beat_d = beat_q;
    end

    play_len    = 32'(next_entry[2:0]) * BEAT_CYCLES;
    play_last_d = CNT_W'(play_len - 32'd1);

    tone_en_d = (state_d == ST_PLAY) && (next_entry[ROM_W-1:3] != '0);
    hp_d      = (state_d == ST_PLAY || state_d == ST_GAP) ? next_entry[ROM_W-1:3] : '0;
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= 3'd0;
      loop_q      <= '0;
      cnt_q       <= '0;
      beat_q      <= '0;
      play_last_q <= '0;
      tone_en_q   <= 1'b0;
      hp_q        <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      loop_q      <= loop_d;
      cnt_q       <= cnt_d;
      beat_q      <= beat_d;
      play_last_q <= play_last_d;
      tone_en_q   <= tone_en_d;
      hp_q        <= hp_d;
      done_q      <= done_d;
    end
  end

  assign tone_en          = tone_en_q;
  assign note_half_period = hp_q;
  assign note_idx         = idx_q;
  assign active           = (state_q == ST_PLAY) || (state_q == ST_GAP);
  assign snoozing         = (state_q == ST_SNOOZE);
  assign done             = done_q;

endmodule

// File: tb/tb_alarm_melody_sequencer.sv
// Directed bench for alarm_melody_sequencer with short beat/gap/snooze timing.
module tb_alarm_melody_sequencer;
  import alarm_pkg::*;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            alarm_trigger = 1'b0;
  logic            snooze = 1'b0;
  logic            stop = 1'b0;
  logic            tone_en;
  logic [16:0]     note_half_period;
  logic [2:0]      note_idx;
  logic            active;
  logic            snoozing;
  logic            done;

  int checks = 0;
  int passed = 0;
  int done_seen = 0;
  logic [23:0] snap, want;
  logic [20:0] snap_m, want_m;

  alarm_melody_sequencer #(
    .BEAT_CYCLES  (10),
    .GAP_CYCLES   (2),
    .SNOOZE_BEATS (5),
    .REPEATS      (2)
  ) dut (
    .CLK100MHZ        (clk),
    .reset            (reset),
    .alarm_trigger    (alarm_trigger),
    .snooze           (snooze),
    .stop             (stop),
    .tone_en          (tone_en),
    .note_half_period (note_half_period),
    .note_idx         (note_idx),
    .active           (active),
    .snoozing         (snoozing),
    .done             (done)
  );

  always #5 clk = ~clk;

  // snap = {tone_en, active, snoozing, done, note_idx, note_half_period}
  assign snap   = {tone_en, active, snoozing, done, note_idx, note_half_period};
  assign snap_m = {tone_en, active, snoozing, done, note_half_period};

  always @(negedge clk) if (done === 1'b1) done_seen++;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic fire_trigger();
    alarm_trigger = 1'b1;
    tick(1);
    alarm_trigger = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(3);
    want = '0;
    checks++; if (snap !== want) $display("[TB] FAIL reset_hold: got %h want %h", snap, want); else passed++;
    reset = 1'b0;
    tick(2);
    checks++; if (snap !== want) $display("[TB] FAIL reset_idle: got %h want %h", snap, want); else passed++;
    snooze = 1'b1;
    tick(1);
    snooze = 1'b0;
    checks++; if (snap !== want) $display("[TB] FAIL snooze_in_idle: got %h want %h", snap, want); else passed++;
  endtask

  task automatic test_trigger();
    int n;
    fire_trigger();
    want = {1'b1, 1'b1, 1'b0, 1'b0, 3'd0, HP_C5};
    checks++; if (snap !== want) $display("[TB] FAIL note0_start: got %h want %h", snap, want); else passed++;
    n = 0;
    while (tone_en === 1'b1 && n < 100) begin
      n++;
      tick(1);
    end
    checks++; if (n !== 20) $display("[TB] FAIL note0_tone_len: got %0d want 20", n); else passed++;
    want = {1'b0, 1'b1, 1'b0, 1'b0, 3'd0, HP_C5};
    checks++; if (snap !== want) $display("[TB] FAIL gap0_hold: got %h want %h", snap, want); else passed++;
    tick(1);
    checks++; if (snap !== want) $display("[TB] FAIL gap0_second: got %h want %h", snap, want); else passed++;
    tick(1);
    want = {1'b1, 1'b1, 1'b0, 1'b0, 3'd1, HP_E5};
    checks++; if (snap !== want) $display("[TB] FAIL note1_start: got %h want %h", snap, want); else passed++;
  endtask

  task automatic test_rest_note();
    tick(42);
    want = {1'b0, 1'b1, 1'b0, 1'b0, 3'd2, HP_G5};
    checks++; if (snap !== want) $display("[TB] FAIL gap2: got %h want %h", snap, want); else passed++;
    tick(2);
    want = {1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 17'd0};
    checks++; if (snap !== want) $display("[TB] FAIL rest_start: got %h want %h", snap, want); else passed++;
    tick(9);
    checks++; if (snap !== want) $display("[TB] FAIL rest_end: got %h want %h", snap, want); else passed++;
    tick(3);
    want = {1'b1, 1'b1, 1'b0, 1'b0, 3'd4, HP_G5};
    checks++; if (snap !== want) $display("[TB] FAIL note4_start: got %h want %h", snap, want); else passed++;
  endtask

  // Melody is 12 beats + 8 gaps = 136 cycles per loop; two loops end at edge 272.
  task automatic test_auto_stop();
    done_seen = 0;
    tick(58);
    want = {1'b1, 1'b1, 1'b0, 1'b0, 3'd0, HP_C5};
    checks++; if (snap !== want) $display("[TB] FAIL loop2_start: got %h want %h", snap, want); else passed++;
    tick(135);
    want = {1'b0, 1'b1, 1'b0, 1'b0, 3'd7, 17'd0};
    checks++; if (snap !== want) $display("[TB] FAIL last_gap: got %h want %h", snap, want); else passed++;
    checks++; if (done_seen !== 0) $display("[TB] FAIL early_done: got %0d want 0", done_seen); else passed++;
    tick(1);
    want = {1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 17'd0};
    checks++; if (snap !== want) $display("[TB] FAIL done_pulse: got %h want %h", snap, want); else passed++;
    tick(1);
    want = '0;
    checks++; if (snap !== want) $display("[TB] FAIL after_done: got %h want %h", snap, want); else passed++;
    tick(20);
    checks++; if (snap !== want) $display("[TB] FAIL idle_after_stop: got %h want %h", snap, want); else passed++;
    checks++; if (done_seen !== 1) $display("[TB] FAIL done_count: got %0d want 1", done_seen); else passed++;
  endtask

  task automatic test_snooze();
    fire_trigger();
    tick(50);
    want = {1'b1, 1'b1, 1'b0, 1'b0, 3'd2, HP_G5};
    checks++; if (snap !== want) $display("[TB] FAIL note2_play: got %h want %h", snap, want); else passed++;
    snooze = 1'b1;
    tick(1);
    snooze = 1'b0;
    want_m = {1'b0, 1'b0, 1'b1, 1'b0, 17'd0};
    checks++; if (snap_m !== want_m) $display("[TB] FAIL snooze_enter: got %h want %h", snap_m, want_m); else passed++;
    tick(9);
    snooze = 1'b1;
    tick(1);
    snooze = 1'b0;
    tick(9);
    alarm_trigger = 1'b1;
    tick(1);
    alarm_trigger = 1'b0;
    checks++; if (snap_m !== want_m) $display("[TB] FAIL snooze_ignores_retrigger: got %h want %h", snap_m, want_m); else passed++;
    tick(29);
    checks++; if (snap_m !== want_m) $display("[TB] FAIL snooze_last: got %h want %h", snap_m, want_m); else passed++;
    tick(1);
    want = {1'b1, 1'b1, 1'b0, 1'b0, 3'd0, HP_C5};
    checks++; if (snap !== want) $display("[TB] FAIL snooze_resume: got %h want %h", snap, want); else passed++;
  endtask

  task automatic test_stop_vs_snooze();
    tick(4);
    stop = 1'b1;
    snooze = 1'b1;
    tick(1);
    stop = 1'b0;
    snooze = 1'b0;
    want = '0;
    checks++; if (snap !== want) $display("[TB] FAIL stop_beats_snooze: got %h want %h", snap, want); else passed++;
    tick(10);
    checks++; if (snap !== want) $display("[TB] FAIL stop_stays_idle: got %h want %h", snap, want); else passed++;
  endtask

  task automatic test_retrigger_in_play();
    fire_trigger();
    tick(5);
    alarm_trigger = 1'b1;
    tick(1);
    alarm_trigger = 1'b0;
    tick(15);
    want = {1'b0, 1'b1, 1'b0, 1'b0, 3'd0, HP_C5};
    checks++; if (snap !== want) $display("[TB] FAIL retrigger_gap: got %h want %h", snap, want); else passed++;
    tick(1);
    want = {1'b1, 1'b1, 1'b0, 1'b0, 3'd1, HP_E5};
    checks++; if (snap !== want) $display("[TB] FAIL retrigger_note1: got %h want %h", snap, want); else passed++;
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
  endtask

  task automatic test_mid_reset();
    fire_trigger();
    tick(100);
    want = {1'b0, 1'b1, 1'b0, 1'b0, 3'd5, HP_E5};
    checks++; if (snap !== want) $display("[TB] FAIL gap5: got %h want %h", snap, want); else passed++;
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    want = '0;
    checks++; if (snap !== want) $display("[TB] FAIL mid_reset: got %h want %h", snap, want); else passed++;
    tick(3);
    checks++; if (snap !== want) $display("[TB] FAIL reset_stays_idle: got %h want %h", snap, want); else passed++;
    fire_trigger();
    want = {1'b1, 1'b1, 1'b0, 1'b0, 3'd0, HP_C5};
    checks++; if (snap !== want) $display("[TB] FAIL restart_after_reset: got %h want %h", snap, want); else passed++;
  endtask

  initial begin
    test_reset();
    test_trigger();
    test_rest_note();
    test_auto_stop();
    test_snooze();
    test_stop_vs_snooze();
    test_retrigger_in_play();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
